// File: rtl/multi_timer.sv
// Memory-mapped 64-bit timer with NCH compare channels, level interrupts and a byte-strobed register window.
// Define TIMER_AUTORELOAD_EN to add per-channel PERIOD registers that re-arm CMP after each match.
module multi_timer #(
  parameter logic [63:0] BASE = 64'h0200_0000,
  parameter int          NCH  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           wr,
  input  logic [7:0]     strb,
  input  logic [63:0]    addr,
  input  logic [63:0]    wdata,
  output logic [63:0]    rdata,
  output logic [NCH-1:0] irq
);

  localparam logic [4:0] W_MTIME = 5'd0;
  localparam logic [4:0] W_CTRL  = 5'd1;
  localparam logic [4:0] W_PEND  = 5'd2;
  localparam int         W_CMP   = 3;
  localparam int         W_PER   = 11;

  logic [63:0]    mtime;
  logic [7:0]     psc;
  logic           run;
  logic [7:0]     div;
  logic [NCH-1:0] ie;
  logic [NCH-1:0] pend;
  logic [63:0]    cmp [NCH];
`ifdef TIMER_AUTORELOAD_EN
  logic [63:0]    period [NCH];
  logic [NCH-1:0] wr_per;
`endif

  logic           sel;
  logic [4:0]     word;
  logic           wr_hit, wr_mtime, wr_ctrl, wr_pend;
  logic [NCH-1:0] wr_cmp;
  logic [NCH-1:0] match;
  logic [NCH-1:0] pend_nxt;
  logic [NCH-1:0] ie_nxt;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    for (int k = 0; k < 8; k++) merge[8*k +: 8] = s[k] ? d[8*k +: 8] : old[8*k +: 8];
  endfunction

  // BASE is assumed 8-byte aligned, so the word index is a 5-bit difference.
  assign sel      = en && (addr >= BASE) && (addr < BASE + 64'h100);
  assign word     = addr[7:3] - BASE[7:3];
  assign wr_hit   = sel && wr;
  assign wr_mtime = wr_hit && (word == W_MTIME);
  assign wr_ctrl  = wr_hit && (word == W_CTRL);
  assign wr_pend  = wr_hit && (word == W_PEND);

  always_comb begin
    wr_cmp = '0;
    match  = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_cmp[i] = wr_hit && (word == 5'(W_CMP + i));
      match[i]  = (mtime >= cmp[i]);
    end
  end

`ifdef TIMER_AUTORELOAD_EN
  always_comb begin
    wr_per = '0;
    for (int i = 0; i < NCH; i++) wr_per[i] = wr_hit && (word == 5'(W_PER + i));
  end
`endif

  // A compare hit sets PEND even if software clears it in the same cycle.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NCH; i++)
      pend_nxt[i] = match[i] | (pend[i] & ~(wr_pend & strb[0] & wdata[i]));
    ie_nxt = (wr_ctrl && strb[2]) ? wdata[16 +: NCH] : ie;
  end

  // A CTRL write restarts the prescaler and skips that cycle's tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= '0;
      psc   <= '0;
      run   <= 1'b0;
      div   <= '0;
      ie    <= '0;
      pend  <= '0;
      irq   <= '0;
    end else begin
      if (wr_mtime) begin
        mtime <= merge(mtime, wdata, strb);
        psc   <= '0;
      end else if (wr_ctrl) begin
        psc   <= '0;
      end else if (run) begin
        if (psc == div) begin
          psc   <= '0;
          mtime <= mtime + 64'd1;
        end else begin
          psc   <= psc + 8'd1;
        end
      end
      if (wr_ctrl && strb[0]) run <= wdata[0];
      if (wr_ctrl && strb[1]) div <= wdata[15:8];
      ie   <= ie_nxt;
      pend <= pend_nxt;
      irq  <= pend_nxt & ie_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cmp[i] <= '1;
`ifdef TIMER_AUTORELOAD_EN
        period[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_cmp[i]) cmp[i] <= merge(cmp[i], wdata, strb);
`ifdef TIMER_AUTORELOAD_EN
        else if (match[i] && (period[i] != 64'd0)) cmp[i] <= cmp[i] + period[i];
        if (wr_per[i]) period[i] <= merge(period[i], wdata, strb);
`endif
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel && !wr) begin
      case (word)
        W_MTIME: rdata = mtime;
        W_CTRL: begin
          rdata[0]        = run;
          rdata[15:8]     = div;
          rdata[16 +: NCH] = ie;
        end
        W_PEND: rdata[NCH-1:0] = pend;
        default: begin
          for (int i = 0; i < NCH; i++) begin
            if (word == 5'(W_CMP + i)) rdata = cmp[i];
`ifdef TIMER_AUTORELOAD_EN
            if (word == 5'(W_PER + i)) rdata = period[i];
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: expected values queued per read, popped and asserted on sampling.
module tb_multi_timer;

  localparam logic [63:0] BASE = 64'h0200_0000;
  localparam int          NCH  = 2;
  localparam logic [7:0]  O_MTIME = 8'h00, O_CTRL = 8'h08, O_PEND = 8'h10;
  localparam logic [7:0]  O_CMP0 = 8'h18, O_CMP1 = 8'h20, O_PER0 = 8'h58;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic           clk, rst, en, wr;
  logic [7:0]     strb;
  logic [63:0]    addr, wdata, rdata;
  logic [NCH-1:0] irq;

  logic [63:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  multi_timer #(.BASE(BASE), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .strb(strb),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: no expected value queued, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // driver tasks
  task automatic wr_raw(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = a; wdata = d; strb = s;
    @(posedge clk);
    #1;
    en = 1'b0; wr = 1'b0; strb = 8'h00;
  endtask

  task automatic wr_reg(input logic [7:0] off, input logic [63:0] d, input logic [7:0] s);
    wr_raw(BASE + 64'(off), d, s);
  endtask

  task automatic rd_raw(input string tag, input logic [63:0] a, input logic e,
                        input logic [63:0] exp);
    exp_q.push_back(exp);
    @(negedge clk);
    en = e; wr = 1'b0; addr = a; strb = $urandom_range(0, 255);
    #1;
    check(tag, rdata);
    en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [63:0] exp);
    rd_raw(tag, BASE + 64'(off), 1'b1, exp);
  endtask

  // Combinational read with no clock wait, used while rst is held.
  task automatic peek(input string tag, input logic [7:0] off, input logic [63:0] exp);
    exp_q.push_back(exp);
    en = 1'b1; wr = 1'b0; addr = BASE + 64'(off);
    #1;
    check(tag, rdata);
    en = 1'b0;
  endtask

  task automatic irq_chk(input string tag, input logic [NCH-1:0] exp);
    exp_q.push_back(64'(exp));
    check(tag, 64'(irq));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr = 1'b0; strb = 8'h00; addr = '0; wdata = '0;
    #12;
    peek("rst_mtime", O_MTIME, 64'd0);
    peek("rst_ctrl", O_CTRL, 64'd0);
    peek("rst_pend", O_PEND, 64'd0);
    peek("rst_cmp0", O_CMP0, ONES);
    peek("rst_cmp1", O_CMP1, ONES);
    irq_chk("rst_irq", 2'b00);

    // write held across an edge while in reset must be dropped
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = BASE + 64'(O_CTRL); wdata = 64'h101; strb = 8'hFF;
    @(posedge clk);
    #1;
    en = 1'b0; wr = 1'b0;
    peek("rst_abort_ctrl", O_CTRL, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // RUN with DIV=1: one tick every two cycles
    wr_reg(O_CTRL, 64'h0000_0101, 8'hFF);
    repeat (10) @(posedge clk);
    rd_chk("div1_mtime", O_MTIME, 64'd5);
    wr_reg(O_CTRL, 64'd0, 8'hFF);
    repeat (5) @(posedge clk);
    rd_chk("stopped_hold", O_MTIME, 64'd5);
    wr_reg(O_CTRL, 64'hFFFF_FFFF_FFFF_FFFE, 8'h06);
    rd_chk("ctrl_fields", O_CTRL, 64'h0000_0000_0003_FF00);
    wr_reg(O_CTRL, 64'd0, 8'hFF);

    // compare, irq, W1C behaviour
    do_reset();
    wr_reg(O_CMP0, 64'd3, 8'hFF);
    wr_reg(O_CTRL, 64'h0001_0001, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    irq_chk("irq_before", 2'b00);
    @(posedge clk);
    #1;
    irq_chk("irq_rise", 2'b01);
    rd_chk("pend_set", O_PEND, 64'd1);
    wr_reg(O_PEND, 64'd1, 8'h01);
    rd_chk("pend_set_wins", O_PEND, 64'd1);
    wr_reg(O_CMP0, ONES, 8'hFF);
    wr_reg(O_PEND, 64'd1, 8'h02);
    rd_chk("pend_no_strb0", O_PEND, 64'd1);
    wr_reg(O_PEND, 64'd1, 8'h01);
    irq_chk("irq_cleared", 2'b00);
    rd_chk("pend_cleared", O_PEND, 64'd0);
    wr_reg(O_CTRL, 64'd0, 8'hFF);

    // byte strobes and decode limits
    wr_reg(O_CMP1, 64'h1122_3344_5566_7788, 8'h0F);
    rd_chk("cmp1_strb", O_CMP1, 64'hFFFF_FFFF_5566_7788);
    rd_raw("above_window", BASE + 64'h100, 1'b1, 64'd0);
    rd_chk("cmp2_absent", 8'h28, 64'd0);
    rd_chk("per0_reset", O_PER0, 64'd0);
    wr_reg(O_MTIME, 64'h1234, 8'hFF);
    wr_raw(BASE + 64'h100, 64'h77, 8'hFF);
    wr_raw(BASE - 64'h100, 64'h88, 8'hFF);
    rd_chk("outside_write", O_MTIME, 64'h1234);
    rd_raw("en_low", BASE + 64'(O_MTIME), 1'b0, 64'd0);

    // wrap of MTIME; all-ones CMP matches at MTIME all-ones
    do_reset();
    wr_reg(O_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    wr_reg(O_CTRL, 64'h1, 8'hFF);
    @(posedge clk);
    rd_chk("wrap_max", O_MTIME, ONES);
    rd_chk("wrap_zero", O_MTIME, 64'd0);
    @(posedge clk);
    rd_chk("wrap_pend", O_PEND, 64'd3);
    irq_chk("wrap_irq_masked", 2'b00);

    // asynchronous reset mid-count
    do_reset();
    wr_reg(O_CMP0, 64'd0, 8'hFF);
    wr_reg(O_CMP1, 64'd0, 8'hFF);
    wr_reg(O_MTIME, 64'h55, 8'hFF);
    wr_reg(O_CTRL, 64'h0003_FF01, 8'hFF);
    rd_chk("pre_mtime", O_MTIME, 64'h55);
    rd_chk("pre_pend", O_PEND, 64'd3);
    irq_chk("pre_irq", 2'b11);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    irq_chk("async_irq", 2'b00);
    peek("async_mtime", O_MTIME, 64'd0);
    peek("async_pend", O_PEND, 64'd0);
    peek("async_ctrl", O_CTRL, 64'd0);
    peek("async_cmp0", O_CMP0, ONES);
    @(negedge clk);
    rst = 1'b0;

`ifdef TIMER_AUTORELOAD_EN
    wr_reg(O_CMP0, 64'd10, 8'hFF);
    wr_reg(O_PER0, 64'd10, 8'hFF);
    wr_reg(O_CTRL, 64'h0001_0001, 8'hFF);
    repeat (10) @(posedge clk);
    rd_chk("ar_cmp_10", O_CMP0, 64'd10);
    rd_chk("ar_cmp_20", O_CMP0, 64'd20);
    wr_reg(O_PEND, 64'd1, 8'h01);
    rd_chk("ar_pend_clr", O_PEND, 64'd0);
    repeat (18) @(posedge clk);
    rd_chk("ar_cmp_40", O_CMP0, 64'd40);
    rd_chk("ar_pend_30", O_PEND, 64'd1);
    rd_chk("ar_period", O_PER0, 64'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
